// File: rtl/pipeline_skid_latch.sv
// Two-entry skid latch between pipeline stages with stall/flush performance counters.
// One cycle accept-to-output latency; in_ready is a registered-state decode (low only when FULL).
module pipeline_skid_latch #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  main_q, main_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   flush_q, flush_d;
    logic               accept;
    logic               pop;
    logic               stall;

    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q == ONE) || (state_q == FULL);
        out_data  = main_q;
        stall_cnt = stall_q;
        flush_cnt = flush_q;
        case (state_q)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;
    assign stall  = out_valid && !out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Flush wins over any same-cycle accept or pop; the incoming payload is dropped.
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (accept && pop) begin
                        main_d  = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (clr_cnt) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (stall && (stall_q != {CNT_W{1'b1}})) begin
                stall_d = stall_q + CNT_W'(1);
            end
            if (flush && (flush_q != {CNT_W{1'b1}})) begin
                flush_d = flush_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

endmodule
